membridge_mem_ctrl: RTL and testbench

Memory-side sequencer for the membridge data path, directly downstream of the data buffer's write FIFO and upstream of its read FIFO. It accepts one burst command at a time (1–8 beats of 64-bit data). Write bursts pop words from the write FIFO and issue single-beat memory writes. Read bursts issue memory reads and push the returned words into the read FIFO, with backpressure from that FIFO.

---
 rtl/membridge_mem_ctrl.sv | 139 +++++++++++++
 tb/tb_membridge_mem_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/membridge_mem_ctrl.sv
// Memory-side burst sequencer: drains the write FIFO into single-beat memory writes and
// fills the read FIFO from single-beat memory reads, with one request outstanding at a time.
module membridge_mem_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_len,
  input  logic              wr_valid,
  input  logic [63:0]       wr_data,
  output logic              wr_ready,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [63:0]       rd_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    StIdle,
    StWrFetch,
    StWrReq,
    StRdWait,
    StRdReq,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              last_beat;

  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = 3'd0;
          state_d = cmd_write ? StWrFetch : StRdWait;
        end
      end
      StWrFetch: begin
        if (wr_valid) begin
          wdata_d = wr_data;
          state_d = StWrReq;
        end
      end
      StWrReq: begin
        if (mem_ack) begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q + 3'd1;
          state_d = last_beat ? StDone : StWrFetch;
        end
      end
      StRdWait: begin
        if (rd_ready) begin
          state_d = StRdReq;
        end
      end
      StRdReq: begin
        if (mem_ack) begin
          rdata_d    = mem_rdata;
          rd_valid_d = 1'b1;
          addr_d     = addr_q + ADDR_W'(1);
          cnt_d      = cnt_q + 3'd1;
          state_d    = last_beat ? StDone : StRdWait;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered so cmd_ready stays low while reset is held and rises once out of reset.
  assign cmd_ready_d = (state_d == StIdle);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= 3'd0;
      cnt_q       <= 3'd0;
      wdata_q     <= 64'd0;
      rdata_q     <= 64'd0;
      rd_valid_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rd_valid_q  <= rd_valid_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = (state_q == StWrFetch) && wr_valid;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rdata_q;
  assign mem_req   = (state_q == StWrReq) || (state_q == StRdReq);
  assign mem_we    = (state_q == StWrReq);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_membridge_mem_ctrl.sv
// Randomized bench for membridge_mem_ctrl: a transaction-level model tracks each burst
// (expected addresses, popped words, returned read data) and checks the DUT every cycle.
module tb_membridge_mem_ctrl;

  localparam int unsigned AW = 32;

  logic          sys_clk;
  logic          sys_rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_len;
  logic          wr_valid;
  logic [63:0]   wr_data;
  logic          wr_ready;
  logic          rd_ready;
  logic          rd_valid;
  logic [63:0]   rd_data;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic          mem_ack;
  logic [63:0]   mem_rdata;
  logic          busy;
  logic          done;

  membridge_mem_ctrl #(
    .ADDR_W(AW)
  ) u_dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus knobs
  int unsigned pct_wv, pct_ack, pct_rr;
  int          ack_delay, wv_hold, stall_beat, stall_left;
  bit          hold_cmd;

  // Command waiting to be issued
  bit          cmd_pend;
  bit          cmd_w;
  logic [AW-1:0] cmd_a;
  logic [2:0]  cmd_l;

  // Burst-level reference model
  bit            in_burst, is_wr, done_exp, rdv_exp, prev_pend, prev_rr, prev_we;
  logic [AW-1:0] base, prev_addr;
  logic [63:0]   prev_wdata;
  int            n, acks, pops, pushes, busy_cnt, last_busy, req_age;
  logic [63:0]   fifo[$];
  logic [63:0]   popped[$];
  logic [63:0]   exp_push[$];

  task automatic set_knobs(input int unsigned wv, input int unsigned ack, input int unsigned rr,
                           input int dly);
    pct_wv     = wv;
    pct_ack    = ack;
    pct_rr     = rr;
    ack_delay  = dly;
    wv_hold    = 0;
    stall_beat = -1;
    stall_left = 0;
  endtask

  task automatic model_clear();
    in_burst  = 1'b0;
    done_exp  = 1'b0;
    rdv_exp   = 1'b0;
    prev_pend = 1'b0;
    prev_rr   = 1'b0;
    cmd_pend  = 1'b0;
    req_age   = 0;
    fifo.delete();
    popped.delete();
    exp_push.delete();
  endtask

  task automatic apply_reset();
    sys_rst   = 1'b1;
    cmd_valid = 1'b0;
    #1;
    check_eq("rst_ctrl", 128'({cmd_ready, wr_ready, rd_valid, mem_req, mem_we, busy, done}),
             128'(0));
    check_eq("rst_addr_wdata", 128'({mem_addr, mem_wdata}), 128'(0));
    check_eq("rst_rd_data", 128'(rd_data), 128'(0));
    model_clear();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // One clock: drive inputs at the falling edge, sample and check, then advance the model
  // by what the next rising edge will do.
  task automatic step();
    logic          ack_now;
    logic          rdv_next;
    logic          done_next;
    logic [AW-1:0] exp_addr;
    @(negedge sys_clk);
    if (mem_req) req_age = prev_pend ? req_age + 1 : 1;
    else         req_age = 0;
    if (mem_req) mem_ack = (req_age > ack_delay) && ($urandom_range(0, 99) < pct_ack);
    else         mem_ack = ($urandom_range(0, 2) == 0);
    mem_rdata = {$urandom, $urandom};
    if (in_burst && wv_hold > 0) begin
      wr_valid = 1'b0;
      wv_hold--;
    end else begin
      wr_valid = ($urandom_range(0, 99) < pct_wv);
    end
    wr_data = (fifo.size() > 0) ? fifo[0] : {$urandom, $urandom};
    if (in_burst && !is_wr && acks == stall_beat && stall_left > 0) begin
      rd_ready = 1'b0;
      stall_left--;
    end else begin
      rd_ready = ($urandom_range(0, 99) < pct_rr);
    end
    if (cmd_pend) begin
      cmd_valid = 1'b1;
      cmd_write = cmd_w;
      cmd_addr  = cmd_a;
      cmd_len   = cmd_l;
    end else begin
      cmd_valid = in_burst && hold_cmd;
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_len   = 3'($urandom);
    end
    #1;

    if (in_burst) busy_cnt++;
    check_eq("busy", 128'(busy), 128'(in_burst));
    check_eq("cmd_ready", 128'(cmd_ready), 128'(!in_burst));
    check_eq("done", 128'(done), 128'(done_exp));
    check_eq("rd_valid", 128'(rd_valid), 128'(rdv_exp));
    if (rd_valid && rdv_exp && exp_push.size() > 0) begin
      check_eq("rd_data", 128'(rd_data), 128'(exp_push.pop_front()));
      pushes++;
    end
    check_eq("wr_ready", 128'(wr_ready),
             128'(wr_valid && in_burst && is_wr && !mem_req && !done_exp && pops == acks));
    if (!in_burst || done_exp) check_eq("idle_req", 128'(mem_req), 128'(0));
    if (prev_pend)
      check_eq("req_hold", 128'({mem_req, mem_we, mem_addr, mem_wdata}),
               128'({1'b1, prev_we, prev_addr, prev_wdata}));
    if (mem_req && !prev_pend && !mem_we) check_eq("rd_gate", 128'(prev_rr), 128'(1));

    ack_now   = mem_req && mem_ack;
    rdv_next  = 1'b0;
    done_next = 1'b0;
    if (ack_now && in_burst) begin
      exp_addr = base + AW'(acks);
      check_eq("mem_addr", 128'(mem_addr), 128'(exp_addr));
      check_eq("mem_we", 128'(mem_we), 128'(is_wr));
      if (is_wr) begin
        if (acks < popped.size()) check_eq("mem_wdata", 128'(mem_wdata), 128'(popped[acks]));
        else check_eq("pop_before_write", 128'(popped.size()), 128'(acks + 1));
      end
    end

    if (wr_ready) begin
      popped.push_back(wr_data);
      if (fifo.size() > 0) void'(fifo.pop_front());
      pops++;
    end
    if (ack_now && in_burst) begin
      if (!is_wr) begin
        exp_push.push_back(mem_rdata);
        rdv_next = 1'b1;
      end
      acks++;
      if (acks == n) done_next = 1'b1;
    end
    if (done_exp) begin
      check_eq("beats", 128'(acks), 128'(n));
      if (is_wr) check_eq("pops", 128'(pops), 128'(n));
      else       check_eq("pushes", 128'(pushes), 128'(n));
      last_busy = busy_cnt;
      in_burst  = 1'b0;
    end
    if (cmd_valid && cmd_ready && !in_burst && cmd_pend) begin
      in_burst = 1'b1;
      is_wr    = cmd_write;
      base     = cmd_addr;
      n        = int'(cmd_len) + 1;
      acks     = 0;
      pops     = 0;
      pushes   = 0;
      busy_cnt = 0;
      popped.delete();
      exp_push.delete();
      cmd_pend = 1'b0;
    end
    prev_pend  = mem_req && !mem_ack;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
    prev_we    = mem_we;
    prev_rr    = rd_ready;
    done_exp   = done_next;
    rdv_exp    = rdv_next;
  endtask

  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [2:0] l);
    fifo.delete();
    if (w) for (int i = 0; i <= int'(l); i++) fifo.push_back({$urandom, $urandom});
    cmd_w    = w;
    cmd_a    = a;
    cmd_l    = l;
    cmd_pend = 1'b1;
  endtask

  task automatic run_burst(input bit w, input logic [AW-1:0] a, input logic [2:0] l,
                           input int exp_cycles);
    int guard;
    issue(w, a, l);
    guard = 0;
    while ((cmd_pend || in_burst) && guard < 3000) begin
      step();
      guard++;
    end
    check_eq("burst_complete", 128'(cmd_pend || in_burst), 128'(0));
    if (cmd_pend || in_burst) apply_reset();
    else if (exp_cycles > 0) check_eq("busy_cycles", 128'(last_busy), 128'(exp_cycles));
    step();
    step();
  endtask

  initial begin
    int   guard;
    bit   w;
    logic [AW-1:0] a;
    sys_rst   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = 3'd0;
    wr_valid  = 1'b0;
    wr_data   = 64'd0;
    rd_ready  = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 64'd0;
    hold_cmd  = 1'b1;
    set_knobs(100, 100, 100, 0);
    model_clear();
    #2;
    apply_reset();

    // Idle with stray acks
    for (int i = 0; i < 10; i++) step();

    // Zero-wait bursts: 2N+1 busy cycles
    run_burst(1'b1, 32'h0000_0100, 3'd3, 9);
    run_burst(1'b0, 32'hFFFF_FFFE, 3'd2, 7);

    // Read FIFO stalls after beat 3
    set_knobs(100, 100, 100, 0);
    stall_beat = 3;
    stall_left = 5;
    run_burst(1'b0, 32'h0000_2000, 3'd7, 0);

    // Empty write FIFO, then slow memory
    set_knobs(100, 100, 100, 3);
    wv_hold = 4;
    run_burst(1'b1, 32'h0000_3000, 3'd1, 0);

    // Reset while a write request is waiting for its ack
    set_knobs(100, 100, 100, 1000);
    issue(1'b1, 32'h0000_4000, 3'd5);
    guard = 0;
    while (!mem_req && guard < 50) begin
      step();
      guard++;
    end
    check_eq("mid_burst_req_seen", 128'(mem_req), 128'(1));
    #2;
    apply_reset();
    set_knobs(100, 100, 100, 0);
    run_burst(1'b0, 32'h0000_5000, 3'd0, 3);

    // Random bursts
    for (int k = 0; k < 30; k++) begin
      set_knobs($urandom_range(40, 100), $urandom_range(40, 100), $urandom_range(40, 100),
                int'($urandom_range(0, 2)));
      w = 1'($urandom);
      a = $urandom_range(0, 1) ? $urandom : (32'hFFFF_FFF8 + AW'($urandom_range(0, 7)));
      run_burst(w, a, 3'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
